// File: rtl/home_event_arbiter.sv
// rtl/home_event_arbiter.sv - round-robin home actuator arbiter with fire override
module home_event_arbiter #(
  parameter int HOLD_CYCLES = 4,
  parameter int T_LOW       = 50,
  parameter int T_HIGH      = 70
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       SFD,
  input  logic       SRD,
  input  logic       SFA,
  input  logic       SW,
  input  logic [6:0] ST,
  output logic       fdoor,
  output logic       rdoor,
  output logic       alarmbuzz,
  output logic       winbuzz,
  output logic       heater,
  output logic       cooler,
  output logic [2:0] display,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, SERVE, GAP} state_t;

  localparam logic [6:0] T_LOW_V  = 7'(T_LOW);
  localparam logic [6:0] T_HIGH_V = 7'(T_HIGH);
  localparam logic [3:0] HOLD_M1  = 4'(HOLD_CYCLES - 1);

  state_t     state_q, state_d;
  logic [5:0] pending_q, pending_d;
  logic [5:0] act_q, act_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] display_q, display_d;
  logic [5:0] req, mask, clr;
  logic [2:0] rr_idx, gnt_idx, cand;
  logic       rr_found;

  function automatic logic [2:0] wrap6(input logic [3:0] v);
    return (v >= 4'd6) ? 3'(v - 4'd6) : v[2:0];
  endfunction

  assign req = {(ST > T_HIGH_V), (ST < T_LOW_V), SW, SFA, SRD, SFD};

  // Round-robin search starts just after the last granted index.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = 3'd0;
    cand     = 3'd0;
    for (int k = 1; k <= 6; k++) begin
      cand = wrap6({1'b0, ptr_q} + 4'(k));
      if (!rr_found && pending_q[cand]) begin
        rr_found = 1'b1;
        rr_idx   = cand;
      end
    end
    gnt_idx = pending_q[2] ? 3'd2 : rr_idx;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    act_d     = act_q;
    display_d = display_q;
    clr       = '0;
    mask      = '0;
    case (state_q)
      IDLE: begin
        if (|pending_q) begin
          state_d   = SERVE;
          cnt_d     = HOLD_M1;
          act_d     = 6'b1 << gnt_idx;
          display_d = gnt_idx + 3'd1;
          clr       = 6'b1 << gnt_idx;
          // Fire grants leave the rotation pointer where it was.
          if (!pending_q[2]) ptr_d = gnt_idx;
        end
      end
      SERVE: begin
        mask = act_q;
        if (cnt_q == 4'd0) begin
          state_d   = GAP;
          act_d     = '0;
          display_d = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    pending_d = (pending_q | (req & ~mask)) & ~clr;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      act_q     <= '0;
      cnt_q     <= '0;
      ptr_q     <= 3'd5;
      display_q <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      act_q     <= act_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      display_q <= display_d;
    end
  end

  assign fdoor     = act_q[0];
  assign rdoor     = act_q[1];
  assign alarmbuzz = act_q[2];
  assign winbuzz   = act_q[3];
  assign heater    = act_q[4];
  assign cooler    = act_q[5];
  assign display   = display_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_home_event_arbiter.sv
// tb/tb_home_event_arbiter.sv - randomized and directed bench for home_event_arbiter
module tb_home_event_arbiter;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic       Rst, SFD, SRD, SFA, SW;
  logic [6:0] ST;
  logic       fdoor0, rdoor0, alarmbuzz0, winbuzz0, heater0, cooler0, busy0;
  logic [2:0] display0;
  logic       fdoor1, rdoor1, alarmbuzz1, winbuzz1, heater1, cooler1, busy1;
  logic [2:0] display1;
  logic [9:0] o0, o1;

  int n_cmp = 0;
  int n_bad = 0;

  home_event_arbiter dut (
    .Clk(Clk), .Rst(Rst), .SFD(SFD), .SRD(SRD), .SFA(SFA), .SW(SW), .ST(ST),
    .fdoor(fdoor0), .rdoor(rdoor0), .alarmbuzz(alarmbuzz0), .winbuzz(winbuzz0),
    .heater(heater0), .cooler(cooler0), .display(display0), .busy(busy0)
  );

  home_event_arbiter #(.HOLD_CYCLES(1)) dut1 (
    .Clk(Clk), .Rst(Rst), .SFD(SFD), .SRD(SRD), .SFA(SFA), .SW(SW), .ST(ST),
    .fdoor(fdoor1), .rdoor(rdoor1), .alarmbuzz(alarmbuzz1), .winbuzz(winbuzz1),
    .heater(heater1), .cooler(cooler1), .display(display1), .busy(busy1)
  );

  assign o0 = {cooler0, heater0, winbuzz0, alarmbuzz0, rdoor0, fdoor0, display0, busy0};
  assign o1 = {cooler1, heater1, winbuzz1, alarmbuzz1, rdoor1, fdoor1, display1, busy1};

  // Reference: left = actuator cycles still to drive, gap = one idle-display cycle after service.
  typedef struct packed {
    int       left;
    int       cur;
    int       ptr;
    bit       gap;
    bit [5:0] pend;
  } model_t;

  model_t m_s [2];

  function automatic logic [5:0] cur_req();
    return {ST > 7'd70, ST < 7'd50, SW, SFA, SRD, SFD};
  endfunction

  function automatic model_t step(model_t s, logic [5:0] req, int hold);
    model_t n = s;
    bit [5:0] np = s.pend;
    int g = -1;
    for (int i = 0; i < 6; i++)
      if (req[i] && !(s.left > 0 && s.cur == i)) np[i] = 1'b1;
    if (s.gap) begin
      n.gap = 1'b0;
    end else if (s.left > 0) begin
      n.left = s.left - 1;
      if (n.left == 0) n.gap = 1'b1;
    end else if (s.pend != 6'd0) begin
      if (s.pend[2]) begin
        g = 2;
      end else begin
        for (int k = 1; k <= 6; k++)
          if (g < 0 && s.pend[(s.ptr + k) % 6]) g = (s.ptr + k) % 6;
        n.ptr = g;
      end
      np[g]  = 1'b0;
      n.left = hold;
      n.cur  = g;
    end
    n.pend = np;
    return n;
  endfunction

  function automatic logic [9:0] exp_vec(model_t s);
    logic [5:0] a = '0;
    logic [2:0] d = '0;
    if (s.left > 0) begin
      a = 6'd1 << s.cur;
      d = 3'(s.cur + 1);
    end
    return {a, d, (s.left > 0) || s.gap};
  endfunction

  always @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      for (int m = 0; m < 2; m++) m_s[m] <= '{left: 0, cur: 0, ptr: 5, gap: 1'b0, pend: 6'd0};
    end else begin
      for (int m = 0; m < 2; m++) m_s[m] <= step(m_s[m], cur_req(), (m == 0) ? 4 : 1);
    end
  end

  task automatic do_reset();
    @(negedge Clk);
    Rst = 1'b0; SFD = 1'b0; SRD = 1'b0; SFA = 1'b0; SW = 1'b0; ST = 7'd60;
    @(negedge Clk);
    Rst = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) begin
      @(negedge Clk);
      n_cmp++;
      if (o0 !== 10'd0) begin n_bad++; $display("FAIL reset_h4 got %b want %b", o0, 10'd0); end
      n_cmp++;
      if (o1 !== 10'd0) begin n_bad++; $display("FAIL reset_h1 got %b want %b", o1, 10'd0); end
    end
    @(negedge Clk);
    Rst = 1'b1;
  endtask

  task automatic test_single_pulse();
    int f_cnt = 0, b_cnt = 0, f1_cnt = 0;
    do_reset();
    SFD = 1'b1;
    @(negedge Clk);
    SFD = 1'b0;
    repeat (12) begin
      @(negedge Clk);
      n_cmp++;
      if (o0 !== exp_vec(m_s[0])) begin n_bad++; $display("FAIL pulse_h4 t=%0t got %b want %b", $time, o0, exp_vec(m_s[0])); end
      n_cmp++;
      if (o1 !== exp_vec(m_s[1])) begin n_bad++; $display("FAIL pulse_h1 t=%0t got %b want %b", $time, o1, exp_vec(m_s[1])); end
      f_cnt  += int'(fdoor0 && display0 == 3'd1);
      b_cnt  += int'(busy0);
      f1_cnt += int'(fdoor1);
    end
    n_cmp++;
    if (f_cnt != 4) begin n_bad++; $display("FAIL pulse_fdoor_cycles got %0d want 4", f_cnt); end
    n_cmp++;
    if (b_cnt != 5) begin n_bad++; $display("FAIL pulse_busy_cycles got %0d want 5", b_cnt); end
    n_cmp++;
    if (f1_cnt != 1) begin n_bad++; $display("FAIL pulse_h1_cycles got %0d want 1", f1_cnt); end
  endtask

  task automatic test_round_robin();
    int seq[$];
    int want[6] = '{1, 2, 4, 1, 2, 4};
    logic [2:0] prev = 3'd0;
    do_reset();
    SFD = 1'b1; SRD = 1'b1; SW = 1'b1;
    repeat (45) begin
      @(negedge Clk);
      n_cmp++;
      if (o0 !== exp_vec(m_s[0])) begin n_bad++; $display("FAIL rr_h4 t=%0t got %b want %b", $time, o0, exp_vec(m_s[0])); end
      n_cmp++;
      if (o1 !== exp_vec(m_s[1])) begin n_bad++; $display("FAIL rr_h1 t=%0t got %b want %b", $time, o1, exp_vec(m_s[1])); end
      if (display0 != 3'd0 && prev == 3'd0) seq.push_back(int'(display0));
      prev = display0;
    end
    SFD = 1'b0; SRD = 1'b0; SW = 1'b0;
    n_cmp++;
    if (seq.size() < 6) begin
      n_bad++; $display("FAIL rr_grant_count got %0d want 6", seq.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_cmp++;
        if (seq[i] != want[i]) begin n_bad++; $display("FAIL rr_order[%0d] got %0d want %0d", i, seq[i], want[i]); end
      end
    end
  endtask

  task automatic test_fire();
    int seq[$];
    int want[3] = '{2, 3, 4};
    logic [2:0] prev = 3'd0;
    bit pulsed = 1'b0;
    do_reset();
    SRD = 1'b1; SW = 1'b1;
    @(negedge Clk);
    SRD = 1'b0; SW = 1'b0;
    repeat (40) begin
      @(negedge Clk);
      n_cmp++;
      if (o0 !== exp_vec(m_s[0])) begin n_bad++; $display("FAIL fire_h4 t=%0t got %b want %b", $time, o0, exp_vec(m_s[0])); end
      n_cmp++;
      if (o1 !== exp_vec(m_s[1])) begin n_bad++; $display("FAIL fire_h1 t=%0t got %b want %b", $time, o1, exp_vec(m_s[1])); end
      if (display0 != 3'd0 && prev == 3'd0) seq.push_back(int'(display0));
      prev = display0;
      if (SFA) SFA = 1'b0;
      else if (!pulsed && display0 == 3'd2) begin SFA = 1'b1; pulsed = 1'b1; end
    end
    n_cmp++;
    if (!pulsed) begin n_bad++; $display("FAIL fire_wait_rdoor got 0 want 1"); end
    n_cmp++;
    if (seq.size() != 3) begin
      n_bad++; $display("FAIL fire_grant_count got %0d want 3", seq.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (seq[i] != want[i]) begin n_bad++; $display("FAIL fire_order[%0d] got %0d want %0d", i, seq[i], want[i]); end
      end
    end
  endtask

  task automatic test_thresholds();
    int vals[6] = '{49, 50, 60, 70, 71, 127};
    for (int v = 0; v < 6; v++) begin
      int want = (vals[v] < 50) ? 5 : (vals[v] > 70) ? 6 : 0;
      int on_cnt = 0, bad_code = 0, b_cnt = 0;
      do_reset();
      ST = 7'(vals[v]);
      repeat (14) begin
        @(negedge Clk);
        n_cmp++;
        if (o0 !== exp_vec(m_s[0])) begin n_bad++; $display("FAIL thr_h4 st=%0d got %b want %b", vals[v], o0, exp_vec(m_s[0])); end
        n_cmp++;
        if (o1 !== exp_vec(m_s[1])) begin n_bad++; $display("FAIL thr_h1 st=%0d got %b want %b", vals[v], o1, exp_vec(m_s[1])); end
        b_cnt += int'(busy0);
        if (display0 != 3'd0) begin
          if (int'(display0) == want) on_cnt++;
          else bad_code++;
        end
      end
      n_cmp++;
      if (bad_code != 0) begin n_bad++; $display("FAIL thr_code st=%0d got %0d wrong want 0", vals[v], bad_code); end
      n_cmp++;
      if (want == 0 && b_cnt != 0) begin
        n_bad++; $display("FAIL thr_idle st=%0d got busy %0d want 0", vals[v], b_cnt);
      end else if (want != 0 && on_cnt < 8) begin
        n_bad++; $display("FAIL thr_on st=%0d got %0d want >=8", vals[v], on_cnt);
      end
    end
    ST = 7'd60;
  endtask

  task automatic test_async_reset();
    bit found = 1'b0;
    int b_cnt = 0;
    do_reset();
    ST = 7'd71;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge Clk);
      n_cmp++;
      if (o0 !== exp_vec(m_s[0])) begin n_bad++; $display("FAIL arst_pre t=%0t got %b want %b", $time, o0, exp_vec(m_s[0])); end
      if (cooler0) found = 1'b1;
    end
    n_cmp++;
    if (!found) begin n_bad++; $display("FAIL arst_wait_cooler got 0 want 1"); end
    @(negedge Clk);
    n_cmp++;
    if (cooler0 !== 1'b1) begin n_bad++; $display("FAIL arst_serve2 got %b want 1", cooler0); end
    Rst = 1'b0;
    ST  = 7'd60;
    #1;
    n_cmp++;
    if ({cooler0, display0, busy0} !== 5'd0) begin n_bad++; $display("FAIL arst_drop got %b want 00000", {cooler0, display0, busy0}); end
    n_cmp++;
    if (o1 !== 10'd0) begin n_bad++; $display("FAIL arst_drop_h1 got %b want 0", o1); end
    @(negedge Clk);
    Rst = 1'b1;
    repeat (10) begin
      @(negedge Clk);
      n_cmp++;
      if (o0 !== exp_vec(m_s[0])) begin n_bad++; $display("FAIL arst_post t=%0t got %b want %b", $time, o0, exp_vec(m_s[0])); end
      b_cnt += int'(busy0) + int'(busy1);
    end
    n_cmp++;
    if (b_cnt != 0) begin n_bad++; $display("FAIL arst_no_grant got %0d want 0", b_cnt); end
  endtask

  task automatic test_hold1();
    int hits[$];
    do_reset();
    SFD = 1'b1;
    for (int c = 0; c < 15; c++) begin
      @(negedge Clk);
      n_cmp++;
      if (o1 !== exp_vec(m_s[1])) begin n_bad++; $display("FAIL h1_h1 t=%0t got %b want %b", $time, o1, exp_vec(m_s[1])); end
      n_cmp++;
      if (o0 !== exp_vec(m_s[0])) begin n_bad++; $display("FAIL h1_h4 t=%0t got %b want %b", $time, o0, exp_vec(m_s[0])); end
      if (fdoor1) hits.push_back(c);
    end
    SFD = 1'b0;
    n_cmp++;
    if (hits.size() < 4) begin
      n_bad++; $display("FAIL h1_grants got %0d want >=4", hits.size());
    end else begin
      for (int i = 1; i < hits.size(); i++) begin
        n_cmp++;
        if (hits[i] - hits[i-1] != 3) begin n_bad++; $display("FAIL h1_period got %0d want 3", hits[i] - hits[i-1]); end
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    repeat (600) begin
      @(negedge Clk);
      n_cmp++;
      if (o0 !== exp_vec(m_s[0])) begin n_bad++; $display("FAIL rand_h4 t=%0t got %b want %b", $time, o0, exp_vec(m_s[0])); end
      n_cmp++;
      if (o1 !== exp_vec(m_s[1])) begin n_bad++; $display("FAIL rand_h1 t=%0t got %b want %b", $time, o1, exp_vec(m_s[1])); end
      SFD = ($urandom_range(0, 7) == 0);
      SRD = ($urandom_range(0, 7) == 0);
      SFA = ($urandom_range(0, 15) == 0);
      SW  = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0) ST = 7'($urandom_range(0, 127));
    end
    SFD = 1'b0; SRD = 1'b0; SFA = 1'b0; SW = 1'b0; ST = 7'd60;
  endtask

  initial begin
    Rst = 1'b1; SFD = 1'b0; SRD = 1'b0; SFA = 1'b0; SW = 1'b0; ST = 7'd60;
    #2 Rst = 1'b0;
    test_reset();
    test_single_pulse();
    test_round_robin();
    test_fire();
    test_thresholds();
    test_async_reset();
    test_hold1();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
